// File: rtl/task_sequencer_pkg.sv
// Shared types and constants for the task sequencer.
// Optional cycle counter in the top is enabled by defining TASK_SEQ_CYCLE_COUNT_EN.
package tasks_parameters;

  localparam int TASK_MASK_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    TM_RESET,
    START,
    WAIT_DONE,
    NEXT,
    FINISH
  } seq_state_e;

  // Low n bits set; n = TASK_MASK_W gives all ones.
  function automatic logic [TASK_MASK_W-1:0] task_limit_mask(input int n);
    logic [TASK_MASK_W:0] one_hot;
    one_hot = {{TASK_MASK_W{1'b0}}, 1'b1};
    one_hot = one_hot << n;
    return one_hot[TASK_MASK_W-1:0] - {{(TASK_MASK_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/task_timeout_timer.sv
// Saturating per-task watchdog; expired is high while the count sits at TIMEOUT_CYCLES-1.
module task_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_rst || clear) begin
      count <= '0;
    end else if (enable && count != SAT) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/task_sequencer.sv
// Runs every enabled task through task_manager one at a time, with per-task timeout.
// Define TASK_SEQ_CYCLE_COUNT_EN to measure start-to-done cycles in o_last_task_cycles.
module task_sequencer
  import tasks_parameters::*;
#(
  parameter int NUMBER_OF_TASKS = 16,
  parameter int TIMEOUT_CYCLES  = 1_000_000,
  parameter int TM_RST_CYCLES   = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_run,
  input  logic                   i_abort,
  input  logic [TASK_MASK_W-1:0] i_enabled_tasks,
  input  logic                   i_tasks_done,
  output logic                   o_tm_rst,
  output logic                   o_start_tests,
  output logic [TASK_MASK_W-1:0] o_current_task_number,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_aborted,
  output logic [TASK_MASK_W-1:0] o_pass_mask,
  output logic [TASK_MASK_W-1:0] o_timeout_mask,
  output logic [TASK_MASK_W-1:0] o_last_task_cycles
);

  localparam logic [TASK_MASK_W-1:0] TASK_LIMIT = task_limit_mask(NUMBER_OF_TASKS);
  localparam logic [5:0] LAST_IDX = 6'(NUMBER_OF_TASKS);
  localparam int RST_W = (TM_RST_CYCLES > 1) ? $clog2(TM_RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] LAST_RST = RST_W'(TM_RST_CYCLES - 1);

  seq_state_e             state;
  logic [5:0]             idx;
  logic [4:0]             sel;
  logic [TASK_MASK_W-1:0] mask;
  logic [RST_W-1:0]       rst_cnt;
  logic                   abort_now;
  logic                   timer_expired;

  assign sel       = idx[4:0] - 5'd1;
  assign abort_now = i_abort && state != IDLE && state != FINISH;

  task_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clear  (state == START),
    .enable (state == WAIT_DONE),
    .expired(timer_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                 <= IDLE;
      idx                   <= 6'd1;
      mask                  <= '0;
      rst_cnt               <= '0;
      o_tm_rst              <= 1'b0;
      o_start_tests         <= 1'b0;
      o_current_task_number <= '0;
      o_busy                <= 1'b0;
      o_done                <= 1'b0;
      o_aborted             <= 1'b0;
      o_pass_mask           <= '0;
      o_timeout_mask        <= '0;
    end else if (abort_now) begin
      state                 <= FINISH;
      o_done                <= 1'b1;
      o_aborted             <= 1'b1;
      o_tm_rst              <= 1'b0;
      o_start_tests         <= 1'b0;
      o_current_task_number <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_run) begin
            mask           <= i_enabled_tasks & TASK_LIMIT;
            o_pass_mask    <= '0;
            o_timeout_mask <= '0;
            o_aborted      <= 1'b0;
            idx            <= 6'd1;
            o_busy         <= 1'b1;
            state          <= SELECT;
          end
        end
        SELECT: begin
          if (idx > LAST_IDX) begin
            o_done <= 1'b1;
            state  <= FINISH;
          end else if (mask[sel]) begin
            o_current_task_number <= {{(TASK_MASK_W-6){1'b0}}, idx};
            o_tm_rst              <= 1'b1;
            rst_cnt               <= '0;
            state                 <= TM_RESET;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        TM_RESET: begin
          if (rst_cnt == LAST_RST) begin
            o_tm_rst      <= 1'b0;
            o_start_tests <= 1'b1;
            state         <= START;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end
        START: begin
          o_start_tests <= 1'b0;
          state         <= WAIT_DONE;
        end
        // Done wins over a timeout landing in the same cycle.
        WAIT_DONE: begin
          if (i_tasks_done) begin
            o_pass_mask[sel]      <= 1'b1;
            o_current_task_number <= '0;
            state                 <= NEXT;
          end else if (timer_expired) begin
            o_timeout_mask[sel]   <= 1'b1;
            o_current_task_number <= '0;
            state                 <= NEXT;
          end
        end
        NEXT: begin
          idx   <= idx + 6'd1;
          state <= SELECT;
        end
        FINISH: begin
          o_current_task_number <= '0;
          o_busy                <= 1'b0;
          state                 <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TASK_SEQ_CYCLE_COUNT_EN
  logic [TASK_MASK_W-1:0] cycle_cnt;

  // Counts WAIT_DONE cycles; the done cycle itself is included in the reported value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cycle_cnt          <= '0;
      o_last_task_cycles <= '0;
    end else begin
      if (state == IDLE && i_run) begin
        o_last_task_cycles <= '0;
      end else if (state == WAIT_DONE && i_tasks_done && !abort_now) begin
        o_last_task_cycles <= (cycle_cnt == '1) ? '1 : cycle_cnt + 32'd1;
      end
      if (state == START) begin
        cycle_cnt <= '0;
      end else if (state == WAIT_DONE && cycle_cnt != '1) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
    end
  end
`else
  assign o_last_task_cycles = '0;
`endif

endmodule
